// File: rtl/pipeline_hazard_ctrl_pkg.sv
// +----------------------------------------------------------------------+
// | pipeline_hazard_ctrl_pkg                                             |
// | Shared types and constants for the Lucid64 hazard sequencer.         |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

package pipeline_hazard_ctrl_pkg;

  typedef enum logic [1:0] {
    DMEM_ST_IDLE = 2'd0,
    DMEM_ST_REQ  = 2'd1,
    DMEM_ST_RSP  = 2'd2
  } dmem_state_e;

  localparam int unsigned PERF_CNT_W = 32;

  function automatic logic [PERF_CNT_W-1:0] sat_inc(input logic [PERF_CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/pipeline_hazard_ctrl_dmem_handshake_fsm.sv
// +----------------------------------------------------------------------+
// | dmem_handshake_fsm                                                   |
// | Data-memory request/response tracker producing mem stall and busy.  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module dmem_handshake_fsm
  import pipeline_hazard_ctrl_pkg::*;
(
  input  logic clk_i,
  input  logic rst_i,
  input  logic mem_valid_i,
  input  logic mem_is_load_i,
  input  logic dmem_gnt_i,
  input  logic dmem_rvalid_i,
  output logic mem_stall_o,
  output logic mem_busy_o
);

  dmem_state_e r_state;
  dmem_state_e w_state_nxt;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= DMEM_ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    mem_stall_o = 1'b0;
    case (r_state)
      DMEM_ST_IDLE: begin
        // A load granted and answered in the same cycle never leaves IDLE.
        if (mem_valid_i) begin
          mem_stall_o = ~(dmem_gnt_i & (~mem_is_load_i | dmem_rvalid_i));
          if (!dmem_gnt_i) begin
            w_state_nxt = DMEM_ST_REQ;
          end else if (mem_is_load_i && !dmem_rvalid_i) begin
            w_state_nxt = DMEM_ST_RSP;
          end
        end
      end
      DMEM_ST_REQ: begin
        mem_stall_o = ~(dmem_gnt_i & ~mem_is_load_i);
        if (dmem_gnt_i) begin
          w_state_nxt = mem_is_load_i ? DMEM_ST_RSP : DMEM_ST_IDLE;
        end
      end
      DMEM_ST_RSP: begin
        mem_stall_o = ~dmem_rvalid_i;
        if (dmem_rvalid_i) begin
          w_state_nxt = DMEM_ST_IDLE;
        end
      end
      default: w_state_nxt = DMEM_ST_IDLE;
    endcase
  end

  assign mem_busy_o = (r_state != DMEM_ST_IDLE) | mem_stall_o;

endmodule

`default_nettype wire

// File: rtl/pipeline_hazard_ctrl.sv
// +----------------------------------------------------------------------+
// | pipeline_hazard_ctrl                                                 |
// | Stall/bubble/squash sequencer for the Lucid64 F/D/EX/MEM pipeline.   |
// | Perf counters built only when LUCID64_PERF_CNT_EN is defined.        |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module pipeline_hazard_ctrl
  import pipeline_hazard_ctrl_pkg::*;
#(
  parameter int unsigned LOAD_USE_CYCLES = 1
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [4:0]            id_rs1_idx_i,
  input  logic                  id_rs1_used_i,
  input  logic [4:0]            id_rs2_idx_i,
  input  logic                  id_rs2_used_i,
  input  logic                  id_valid_i,
  input  logic                  ex_valid_i,
  input  logic [4:0]            ex_rd_idx_i,
  input  logic                  ex_rd_wr_en_i,
  input  logic                  ex_mem_rd_i,
  input  logic                  ex_redirect_i,
  input  logic                  mem_valid_i,
  input  logic                  mem_is_load_i,
  input  logic                  dmem_gnt_i,
  input  logic                  dmem_rvalid_i,
  output logic                  fetch_stall_o,
  output logic                  fetch_squash_o,
  output logic                  decode_stall_o,
  output logic                  decode_bubble_o,
  output logic                  decode_squash_o,
  output logic                  ex_stall_o,
  output logic                  mem_busy_o,
  output logic [PERF_CNT_W-1:0] stall_cnt_o,
  output logic [PERF_CNT_W-1:0] squash_cnt_o,
  output logic [PERF_CNT_W-1:0] load_use_cnt_o
);

  localparam logic [1:0] C_LU_RELOAD = 2'(LOAD_USE_CYCLES - 1);

  logic       w_mem_stall;
  logic       w_mem_busy;
  logic       w_hz;
  logic       w_redir;
  logic       w_lu_active;
  logic       w_lu_stall;
  logic [1:0] r_lu_cnt;

  dmem_handshake_fsm u_dmem_fsm (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .mem_valid_i   (mem_valid_i),
    .mem_is_load_i (mem_is_load_i),
    .dmem_gnt_i    (dmem_gnt_i),
    .dmem_rvalid_i (dmem_rvalid_i),
    .mem_stall_o   (w_mem_stall),
    .mem_busy_o    (w_mem_busy)
  );

  assign w_hz = ex_valid_i & ex_mem_rd_i & ex_rd_wr_en_i & (ex_rd_idx_i != 5'd0) & id_valid_i &
                ((id_rs1_used_i & (id_rs1_idx_i == ex_rd_idx_i)) |
                 (id_rs2_used_i & (id_rs2_idx_i == ex_rd_idx_i)));

  // EX is frozen during a memory stall, so a redirect then is simply re-presented later.
  assign w_redir     = ex_redirect_i & ~w_mem_stall;
  assign w_lu_active = w_hz | (r_lu_cnt != 2'd0);
  assign w_lu_stall  = w_lu_active & ~w_redir & ~w_mem_stall;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_lu_cnt <= 2'd0;
    end else if (!w_mem_stall) begin
      if (w_redir) begin
        r_lu_cnt <= 2'd0;
      end else if (w_hz) begin
        r_lu_cnt <= C_LU_RELOAD;
      end else if (r_lu_cnt != 2'd0) begin
        r_lu_cnt <= r_lu_cnt - 2'd1;
      end
    end
  end

  assign fetch_stall_o   = ~rst_i & (w_mem_stall | w_lu_stall);
  assign decode_stall_o  = ~rst_i & w_mem_stall;
  assign ex_stall_o      = ~rst_i & w_mem_stall;
  assign decode_bubble_o = ~rst_i & w_lu_stall;
  assign fetch_squash_o  = ~rst_i & w_redir;
  assign decode_squash_o = ~rst_i & w_redir;
  assign mem_busy_o      = ~rst_i & w_mem_busy;

`ifdef LUCID64_PERF_CNT_EN
  logic [PERF_CNT_W-1:0] r_stall_cnt;
  logic [PERF_CNT_W-1:0] r_squash_cnt;
  logic [PERF_CNT_W-1:0] r_lu_evt_cnt;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_stall_cnt  <= '0;
      r_squash_cnt <= '0;
      r_lu_evt_cnt <= '0;
    end else begin
      if (w_mem_stall | w_lu_stall) r_stall_cnt <= sat_inc(r_stall_cnt);
      if (w_redir) r_squash_cnt <= sat_inc(r_squash_cnt);
      if (w_hz && !w_mem_stall && (r_lu_cnt == 2'd0)) r_lu_evt_cnt <= sat_inc(r_lu_evt_cnt);
    end
  end

  assign stall_cnt_o    = rst_i ? '0 : r_stall_cnt;
  assign squash_cnt_o   = rst_i ? '0 : r_squash_cnt;
  assign load_use_cnt_o = rst_i ? '0 : r_lu_evt_cnt;
`else
  assign stall_cnt_o    = '0;
  assign squash_cnt_o   = '0;
  assign load_use_cnt_o = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_pipeline_hazard_ctrl.sv
// +----------------------------------------------------------------------+
// | tb_pipeline_hazard_ctrl                                              |
// | Directed bench: two instances (LOAD_USE_CYCLES = 1 and 2).           |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_pipeline_hazard_ctrl;

  logic       clk;
  logic       rst;
  logic [4:0] rs1_idx, rs2_idx, rd_idx;
  logic       rs1_used, rs2_used, id_valid;
  logic       ex_valid, rd_wr_en, ex_mem_rd, redirect;
  logic       mem_valid, mem_is_load, gnt, rvalid;

  logic        fs_a, fsq_a, ds_a, db_a, dsq_a, es_a, mb_a;
  logic        fs_b, fsq_b, ds_b, db_b, dsq_b, es_b, mb_b;
  logic [31:0] stc_a, sqc_a, luc_a, stc_b, sqc_b, luc_b;

  wire [6:0] flags_a = {fs_a, fsq_a, ds_a, db_a, dsq_a, es_a, mb_a};
  wire [6:0] flags_b = {fs_b, fsq_b, ds_b, db_b, dsq_b, es_b, mb_b};

  int checks = 0;
  int errors = 0;

  pipeline_hazard_ctrl #(.LOAD_USE_CYCLES(1)) dut_a (
    .clk_i(clk), .rst_i(rst),
    .id_rs1_idx_i(rs1_idx), .id_rs1_used_i(rs1_used),
    .id_rs2_idx_i(rs2_idx), .id_rs2_used_i(rs2_used), .id_valid_i(id_valid),
    .ex_valid_i(ex_valid), .ex_rd_idx_i(rd_idx), .ex_rd_wr_en_i(rd_wr_en),
    .ex_mem_rd_i(ex_mem_rd), .ex_redirect_i(redirect),
    .mem_valid_i(mem_valid), .mem_is_load_i(mem_is_load),
    .dmem_gnt_i(gnt), .dmem_rvalid_i(rvalid),
    .fetch_stall_o(fs_a), .fetch_squash_o(fsq_a), .decode_stall_o(ds_a),
    .decode_bubble_o(db_a), .decode_squash_o(dsq_a), .ex_stall_o(es_a),
    .mem_busy_o(mb_a), .stall_cnt_o(stc_a), .squash_cnt_o(sqc_a), .load_use_cnt_o(luc_a)
  );

  pipeline_hazard_ctrl #(.LOAD_USE_CYCLES(2)) dut_b (
    .clk_i(clk), .rst_i(rst),
    .id_rs1_idx_i(rs1_idx), .id_rs1_used_i(rs1_used),
    .id_rs2_idx_i(rs2_idx), .id_rs2_used_i(rs2_used), .id_valid_i(id_valid),
    .ex_valid_i(ex_valid), .ex_rd_idx_i(rd_idx), .ex_rd_wr_en_i(rd_wr_en),
    .ex_mem_rd_i(ex_mem_rd), .ex_redirect_i(redirect),
    .mem_valid_i(mem_valid), .mem_is_load_i(mem_is_load),
    .dmem_gnt_i(gnt), .dmem_rvalid_i(rvalid),
    .fetch_stall_o(fs_b), .fetch_squash_o(fsq_b), .decode_stall_o(ds_b),
    .decode_bubble_o(db_b), .decode_squash_o(dsq_b), .ex_stall_o(es_b),
    .mem_busy_o(mb_b), .stall_cnt_o(stc_b), .squash_cnt_o(sqc_b), .load_use_cnt_o(luc_b)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Flag bit order: fetch_stall, fetch_squash, decode_stall, decode_bubble, decode_squash, ex_stall, mem_busy
  localparam logic [6:0] NONE   = 7'b0000000;
  localparam logic [6:0] BUBBLE = 7'b1001000;
  localparam logic [6:0] MSTALL = 7'b1010011;
  localparam logic [6:0] BUSY   = 7'b0000001;
  localparam logic [6:0] SQUASH = 7'b0100100;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    rs1_idx = 5'd0; rs2_idx = 5'd0; rd_idx = 5'd0;
    rs1_used = 1'b0; rs2_used = 1'b0; id_valid = 1'b0;
    ex_valid = 1'b0; rd_wr_en = 1'b0; ex_mem_rd = 1'b0; redirect = 1'b0;
    mem_valid = 1'b0; mem_is_load = 1'b0; gnt = 1'b0; rvalid = 1'b0;
  endtask

  // lw x5 in EX; decode reads rs1 = x3 and rs2 = x5
  task automatic set_hazard();
    ex_valid = 1'b1; ex_mem_rd = 1'b1; rd_wr_en = 1'b1; rd_idx = 5'd5;
    id_valid = 1'b1; rs1_idx = 5'd3; rs1_used = 1'b1; rs2_idx = 5'd5; rs2_used = 1'b1;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst = 1'b1; mem_valid = 1'b1; redirect = 1'b1;
    set_hazard();
    #1;
    checks++;
    if ({flags_a, flags_b} !== {NONE, NONE}) begin
      errors++; $display("FAIL reset_pre_edge got %b/%b exp %b", flags_a, flags_b, NONE);
    end
    tick();
    checks++;
    if ({flags_a, flags_b, stc_a, sqc_a, luc_a} !== {NONE, NONE, 96'd0}) begin
      errors++; $display("FAIL reset_state got %b/%b cnt %0d/%0d/%0d", flags_a, flags_b, stc_a, sqc_a, luc_a);
    end
    tick();
    rst = 1'b0;
    clear_inputs();
    #1;
    checks++;
    if ({flags_a, flags_b} !== {NONE, NONE}) begin
      errors++; $display("FAIL reset_release got %b/%b exp %b", flags_a, flags_b, NONE);
    end
    tick();
  endtask

  task automatic test_load_use();
    logic [6:0] exp_a [3] = '{BUBBLE, NONE, NONE};
    logic [6:0] exp_b [3] = '{BUBBLE, BUBBLE, NONE};
    for (int c = 0; c < 3; c++) begin
      clear_inputs();
      if (c == 0) set_hazard();
      #1;
      checks++;
      if (flags_a !== exp_a[c]) begin
        errors++; $display("FAIL load_use_lu1[%0d] got %b exp %b", c, flags_a, exp_a[c]);
      end
      checks++;
      if (flags_b !== exp_b[c]) begin
        errors++; $display("FAIL load_use_lu2[%0d] got %b exp %b", c, flags_b, exp_b[c]);
      end
      tick();
    end
  endtask

  task automatic test_no_hazard();
    logic [6:0] exp_a [7] = '{NONE, NONE, NONE, NONE, BUBBLE, NONE, NONE};
    logic [6:0] exp_b [7] = '{NONE, NONE, NONE, NONE, BUBBLE, BUBBLE, NONE};
    for (int c = 0; c < 7; c++) begin
      clear_inputs();
      if (c < 5) set_hazard();
      case (c)
        0: rd_idx = 5'd0;
        1: rs2_used = 1'b0;
        2: rd_wr_en = 1'b0;
        3: id_valid = 1'b0;
        4: begin rs1_idx = 5'd5; rs2_used = 1'b0; end
        default: ;
      endcase
      #1;
      checks++;
      if (flags_a !== exp_a[c]) begin
        errors++; $display("FAIL no_hazard_lu1[%0d] got %b exp %b", c, flags_a, exp_a[c]);
      end
      checks++;
      if (flags_b !== exp_b[c]) begin
        errors++; $display("FAIL no_hazard_lu2[%0d] got %b exp %b", c, flags_b, exp_b[c]);
      end
      tick();
    end
  endtask

  task automatic test_store();
    logic [6:0] exp_f [5] = '{MSTALL, MSTALL, MSTALL, BUSY, NONE};
    for (int c = 0; c < 5; c++) begin
      clear_inputs();
      if (c < 4) begin mem_valid = 1'b1; gnt = (c == 3); end
      #1;
      checks++;
      if ({flags_a, flags_b} !== {exp_f[c], exp_f[c]}) begin
        errors++; $display("FAIL store_gnt_delay[%0d] got %b/%b exp %b", c, flags_a, flags_b, exp_f[c]);
      end
      tick();
    end
  endtask

  task automatic test_load();
    logic [6:0] exp_f [6] = '{MSTALL, MSTALL, MSTALL, MSTALL, BUSY, NONE};
    for (int c = 0; c < 6; c++) begin
      clear_inputs();
      if (c < 5) begin
        mem_valid = 1'b1; mem_is_load = 1'b1; gnt = (c == 0); rvalid = (c == 4);
      end
      #1;
      checks++;
      if ({flags_a, flags_b} !== {exp_f[c], exp_f[c]}) begin
        errors++; $display("FAIL load_rsp_delay[%0d] got %b/%b exp %b", c, flags_a, flags_b, exp_f[c]);
      end
      tick();
    end
    for (int c = 0; c < 2; c++) begin
      clear_inputs();
      if (c == 0) begin mem_valid = 1'b1; mem_is_load = 1'b1; gnt = 1'b1; rvalid = 1'b1; end
      #1;
      checks++;
      if ({flags_a, flags_b} !== {NONE, NONE}) begin
        errors++; $display("FAIL load_same_cycle[%0d] got %b/%b exp %b", c, flags_a, flags_b, NONE);
      end
      tick();
    end
  endtask

  task automatic test_redirect_mem();
    logic [6:0] exp_f [4] = '{MSTALL, MSTALL, SQUASH | BUSY, NONE};
    for (int c = 0; c < 4; c++) begin
      clear_inputs();
      if (c < 3) begin mem_valid = 1'b1; gnt = (c == 2); redirect = 1'b1; end
      #1;
      checks++;
      if ({flags_a, flags_b} !== {exp_f[c], exp_f[c]}) begin
        errors++; $display("FAIL redirect_in_stall[%0d] got %b/%b exp %b", c, flags_a, flags_b, exp_f[c]);
      end
      tick();
    end
  endtask

  task automatic test_redirect_hz();
    logic [6:0] exp_f [2] = '{SQUASH, NONE};
    for (int c = 0; c < 2; c++) begin
      clear_inputs();
      if (c == 0) begin set_hazard(); redirect = 1'b1; end
      #1;
      checks++;
      if ({flags_a, flags_b} !== {exp_f[c], exp_f[c]}) begin
        errors++; $display("FAIL redirect_vs_hz[%0d] got %b/%b exp %b", c, flags_a, flags_b, exp_f[c]);
      end
      tick();
    end
  endtask

  task automatic test_counters();
    logic [191:0] exp_cnt;
`ifdef LUCID64_PERF_CNT_EN
    exp_cnt = {32'd11, 32'd2, 32'd3, 32'd13, 32'd2, 32'd3};
`else
    exp_cnt = '0;
`endif
    checks++;
    if ({stc_a, sqc_a, luc_a, stc_b, sqc_b, luc_b} !== exp_cnt) begin
      errors++;
      $display("FAIL perf_counters got %0d/%0d/%0d %0d/%0d/%0d exp %h", stc_a, sqc_a, luc_a,
               stc_b, sqc_b, luc_b, exp_cnt);
    end
  endtask

  task automatic test_reset_rsp();
    logic [6:0] exp_f [4] = '{MSTALL, NONE, NONE, NONE};
    for (int c = 0; c < 4; c++) begin
      clear_inputs();
      rst = (c == 1);
      if (c < 2) begin mem_valid = 1'b1; mem_is_load = 1'b1; gnt = (c == 0); end
      if (c == 2) rvalid = 1'b1;
      #1;
      checks++;
      if ({flags_a, flags_b} !== {exp_f[c], exp_f[c]}) begin
        errors++; $display("FAIL reset_in_rsp[%0d] got %b/%b exp %b", c, flags_a, flags_b, exp_f[c]);
      end
      tick();
    end
    checks++;
    if ({stc_a, sqc_a, luc_a} !== 96'd0) begin
      errors++; $display("FAIL counters_after_reset got %0d/%0d/%0d exp 0", stc_a, sqc_a, luc_a);
    end
  endtask

  initial begin
    rst = 1'b1;
    clear_inputs();
    test_reset();
    test_load_use();
    test_no_hazard();
    test_store();
    test_load();
    test_redirect_mem();
    test_redirect_hz();
    test_counters();
    test_reset_rsp();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
